// File: rtl/tabla_pkg.sv
// Shared definitions for the Tabla 01 truth-table sweeper and the mux benches.
package tabla_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_e;

  // Expected Y column of Tabla 01; bit k is Y for input vector k (A = MSB).
  localparam logic [7:0] TABLA01_MUX_EXPECTED = 8'b0110_1001;

  // Number of input vectors for an n-input function.
  function automatic int unsigned vec_count(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/tabla_sweeper_settle_timer.sv
// Settle timer: loadable down-counter. Loaded with SETTLE-1 when a vector is
// first driven, so o_expired rises on the SETTLE-th drive cycle.
module settle_timer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned   CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

  logic [CW-1:0] r_count;

  // Load takes priority; count down and stick at terminal count.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/tabla_sweeper.sv
// Truth-table sweeper: drives every input vector in ascending order, samples
// the function output after a settle period and checks it against TABLE.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for start; abc_out holds the last vector
//   ST_DRIVE  | abc_out = index, waiting SETTLE cycles for y_in to settle
//   ST_SAMPLE | one cycle; y_in compared with TABLE[index] at its end
//   ST_DONE   | one cycle; done pulse, pass computed; start re-triggers here
//
// Re-triggering straight from ST_DONE keeps back-to-back sweeps at one done
// every 2^N_IN*(SETTLE+1)+1 cycles. On that path pass is refreshed rather
// than cleared so it stays readable between sweeps.
module tabla_sweeper
  import tabla_pkg::*;
#(
  parameter int unsigned             N_IN   = 3,
  parameter logic [(1<<N_IN)-1:0]    TABLE  = '0,
  parameter int unsigned             SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            y_in,
  output logic [N_IN-1:0] abc_out,
  output logic            busy,
  output logic            sample_valid,
  output logic            expected,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_idx
);

  localparam int unsigned     VEC_CNT  = vec_count(N_IN);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(VEC_CNT - 1);

  sweep_state_e    r_state, w_state_nxt;
  logic [N_IN-1:0] r_index;
  logic [N_IN:0]   r_err_count;
  logic [N_IN-1:0] r_first_err_idx;
  logic            r_pass, r_busy, r_sample_valid, r_expected, r_done;
  logic            w_tmr_load, w_tmr_en, w_tmr_expired;
  logic            w_start_new, w_restart, w_last, w_mismatch;

  settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_load    (w_tmr_load),
    .i_en      (w_tmr_en),
    .o_expired (w_tmr_expired)
  );

  assign w_last     = (r_index == LAST_IDX);
  assign w_mismatch = (y_in != TABLE[r_index]);

  // Next-state and timer control.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_en    = 1'b0;
    w_start_new = 1'b0;
    w_restart   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_DRIVE;
          w_tmr_load  = 1'b1;
          w_start_new = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (w_tmr_expired) w_state_nxt = ST_SAMPLE;
        else               w_tmr_en    = 1'b1;
      end
      ST_SAMPLE: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRIVE;
          w_tmr_load  = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_DRIVE;
          w_tmr_load  = 1'b1;
          w_restart   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, sweep datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_index         <= '0;
      r_err_count     <= '0;
      r_first_err_idx <= '0;
      r_pass          <= 1'b0;
      r_busy          <= 1'b0;
      r_sample_valid  <= 1'b0;
      r_expected      <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_start_new || w_restart) begin
        r_index         <= '0;
        r_err_count     <= '0;
        r_first_err_idx <= '0;
      end else if (r_state == ST_SAMPLE) begin
        if (w_mismatch) begin
          r_err_count <= r_err_count + (N_IN+1)'(1);
          if (r_err_count == '0) r_first_err_idx <= r_index;
        end
        if (!w_last) r_index <= r_index + N_IN'(1);
      end

      if (w_start_new)               r_pass <= 1'b0;
      else if (r_state == ST_DONE)   r_pass <= (r_err_count == '0);

      r_busy         <= (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_SAMPLE);
      r_sample_valid <= (w_state_nxt == ST_SAMPLE);
      r_expected     <= (w_state_nxt == ST_SAMPLE) ? TABLE[r_index] : 1'b0;
      r_done         <= (w_state_nxt == ST_DONE);
    end
  end

  assign abc_out       = r_index;
  assign busy          = r_busy;
  assign sample_valid  = r_sample_valid;
  assign expected      = r_expected;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_count     = r_err_count;
  assign first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_tabla_sweeper.sv
// Directed bench for tabla_sweeper: one instance with TABLE=1010_1010 and
// SETTLE=1, one with the Tabla 01 column and SETTLE=3 fed by an 8:1 mux model.
module tb_tabla_sweeper;
  import tabla_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: TABLE = 1010_1010, SETTLE = 1
  logic       start_a, y_a, ymode_a;
  logic [2:0] abc_a, ferr_a;
  logic [3:0] err_a;
  logic       busy_a, sv_a, exp_a, done_a, pass_a;

  // Instance B: Tabla 01 column, SETTLE = 3
  logic       start_b, y_b;
  logic [2:0] abc_b, ferr_b;
  logic [3:0] err_b;
  logic       busy_b, sv_b, exp_b, done_b, pass_b;

  logic [7:0] tbl_a   = 8'b1010_1010;
  logic [7:0] tbl_mux = TABLA01_MUX_EXPECTED;

  assign y_a = ymode_a ? 1'b0 : abc_a[0];
  assign y_b = tbl_mux[abc_b];

  tabla_sweeper #(.N_IN(3), .TABLE(8'b1010_1010), .SETTLE(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .y_in(y_a),
    .abc_out(abc_a), .busy(busy_a), .sample_valid(sv_a), .expected(exp_a),
    .done(done_a), .pass(pass_a), .err_count(err_a), .first_err_idx(ferr_a)
  );

  tabla_sweeper #(.N_IN(3), .TABLE(TABLA01_MUX_EXPECTED), .SETTLE(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .y_in(y_b),
    .abc_out(abc_b), .busy(busy_b), .sample_valid(sv_b), .expected(exp_b),
    .done(done_b), .pass(pass_b), .err_count(err_b), .first_err_idx(ferr_b)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, ".abc"},  32'(abc_a),  0);
    chk({tag, ".busy"}, 32'(busy_a), 0);
    chk({tag, ".sv"},   32'(sv_a),   0);
    chk({tag, ".exp"},  32'(exp_a),  0);
    chk({tag, ".done"}, 32'(done_a), 0);
    chk({tag, ".pass"}, 32'(pass_a), 0);
    chk({tag, ".err"},  32'(err_a),  0);
    chk({tag, ".ferr"}, 32'(ferr_a), 0);
  endtask

  // One sweep on instance A; called #1 after an edge with A idle.
  // poke_n > 0 pulses start during that cycle (mid-sweep, must be ignored).
  task automatic sweep_a(input string tag, input int exp_err, input int exp_first,
                         input int exp_pass, input int poke_n);
    int done_at = 0;
    int n_done  = 0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      start_a = (n == poke_n);
      if (n <= 16) begin
        chk({tag, ".abc"},  32'(abc_a),  32'((n - 1) / 2));
        chk({tag, ".busy"}, 32'(busy_a), 1);
        chk({tag, ".sv"},   32'(sv_a),   32'(((n - 1) % 2) == 1));
        if (((n - 1) % 2) == 1)
          chk({tag, ".exp"}, 32'(exp_a), 32'(tbl_a[(n - 1) / 2]));
      end
      if (n == 17) chk({tag, ".busy_done"}, 32'(busy_a), 0);
      if (n == 18) begin
        chk({tag, ".pass"}, 32'(pass_a), 32'(exp_pass));
        chk({tag, ".err"},  32'(err_a),  32'(exp_err));
        chk({tag, ".ferr"}, 32'(ferr_a), 32'(exp_first));
        chk({tag, ".abc_hold"}, 32'(abc_a), 7);
      end
      if (done_a) begin
        n_done++;
        if (done_at == 0) done_at = n;
      end
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    chk({tag, ".done_at"}, 32'(done_at), 17);
    chk({tag, ".n_done"},  32'(n_done),  1);
  endtask

  initial begin
    int done_at_b, n_sv_b;
    int dq[$];

    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; ymode_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_a_zero("rst");
    chk("rst.b_busy", 32'(busy_b), 0);
    chk("rst.b_abc",  32'(abc_b),  0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // y = C tracks TABLE 1010_1010 exactly
    sweep_a("match", 0, 0, 1, 0);

    // y stuck at 0: mismatches at vectors 1,3,5,7
    ymode_a = 1'b1;
    sweep_a("stuck0", 4, 1, 0, 0);

    // 8:1 mux of Tabla 01 with SETTLE=3
    done_at_b = 0; n_sv_b = 0;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n <= 32) chk("mux.abc", 32'(abc_b), 32'((n - 1) / 4));
      if (sv_b) n_sv_b++;
      if (done_b && done_at_b == 0) done_at_b = n;
      @(posedge clk); #1;
    end
    chk("mux.done_at", 32'(done_at_b), 33);
    chk("mux.n_sv",    32'(n_sv_b),    8);
    chk("mux.pass",    32'(pass_b),    1);
    chk("mux.err",     32'(err_b),     0);

    // start pulsed while index 4 is driven: ignored
    ymode_a = 1'b0;
    sweep_a("poke", 0, 0, 1, 9);

    // reset during SAMPLE of index 5
    ymode_a = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    chk("midrst.sv",  32'(sv_a),  1);
    chk("midrst.abc", 32'(abc_a), 5);
    chk("midrst.err", 32'(err_a), 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_a_zero("midrst");
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("midrst.idle", 32'(busy_a), 0);
    ymode_a = 1'b0;
    sweep_a("restart", 0, 0, 1, 0);

    // start held high: back-to-back sweeps
    start_a = 1'b1;
    @(posedge clk); #1;
    for (int n = 1; n <= 80; n++) begin
      if (done_a) dq.push_back(n);
      if (n == 10) chk("b2b.pass_clr", 32'(pass_a), 0);
      if (n == 18 || n == 35 || n == 52) chk("b2b.pass_hold", 32'(pass_a), 1);
      if (n == 52) start_a = 1'b0;
      @(posedge clk); #1;
    end
    chk("b2b.n_done", 32'(dq.size()), 4);
    if (dq.size() == 4) begin
      chk("b2b.first", 32'(dq[0]), 17);
      for (int i = 1; i < 4; i++) chk("b2b.period", 32'(dq[i] - dq[i-1]), 17);
    end
    chk("b2b.idle", 32'(busy_a), 0);
    chk("b2b.pass", 32'(pass_a), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/tabla_sweeper.md
# tabla_sweeper

Sequential truth-table stimulus and checker stage that sits directly upstream of the lab multiplexer implementations (2:1, 4:1, 8:1 realisations of "Tabla 01"). On `start` it drives every input combination of the N-input function under test in ascending binary order, holds each one for a settle period, samples the function output, and compares it against a parameterised expected table. It reports a pass/fail verdict, the number of mismatches and the first failing index, so the function can be checked on a board or in simulation without a hand-written stimulus list.

## Interface
Parameters:
- `N_IN`, 3: number of function inputs; 2^N_IN vectors are swept.
- `TABLE`, 8'b0000_0000: expected output; bit k is the expected Y for input vector k. Width is 2^N_IN.
- `SETTLE`, 1: cycles each vector is held before sampling. Must be ≥1.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `start`, input, 1: begins a sweep when sampled high in IDLE.
- `y_in`, input, 1: output of the function under test.
- `abc_out`, output, N_IN: current input vector; MSB = A, LSB = last input (C for N_IN=3).
- `busy`, output, 1: high from the first drive cycle through the last sample cycle.
- `sample_valid`, output, 1: one-cycle strobe when `y_in` is sampled.
- `expected`, output, 1: `TABLE[abc_out]`, valid with `sample_valid`.
- `done`, output, 1: one-cycle pulse at the end of the sweep.
- `pass`, output, 1: high when the completed sweep had zero mismatches; held until the next `start`.
- `err_count`, output, N_IN+1: mismatches in the current or last sweep.
- `first_err_idx`, output, N_IN: index of the first mismatch; 0 when none.

## Operation
- FSM states are IDLE, DRIVE, SAMPLE and DONE.
- IDLE → DRIVE when `start`=1. On that transition: index ← 0, `err_count` ← 0, `pass` ← 0, `first_err_idx` ← 0, settle counter ← 0.
- DRIVE: `abc_out` = index. The settle counter increments each cycle. After `SETTLE` cycles in DRIVE, go to SAMPLE.
- SAMPLE is one cycle long:
  - assert `sample_valid` and compare `y_in` with `TABLE[index]`;
  - on mismatch, increment `err_count`; if this is the first mismatch, latch `first_err_idx` ← index;
  - if index = 2^N_IN−1, go to DONE; otherwise index increments and the FSM returns to DRIVE.
- DONE is one cycle long: `done`=1 and `pass` ← (`err_count`==0). Then go to IDLE.
- `abc_out` holds the last vector while in IDLE and DONE.
- `start` is ignored outside IDLE. It is level-sampled, so `start` held high re-triggers a sweep on the cycle after DONE.
- Index wraps only by completing the sweep; it never wraps inside a sweep.
- `err_count` cannot overflow: its maximum is 2^N_IN, which fits in N_IN+1 bits.

## Timing
- Reset (`rst_n`=0 at a rising edge) forces IDLE from any state, including mid-sweep. All outputs are 0 after reset: `abc_out`, `busy`, `sample_valid`, `expected`, `done`, `pass`, `err_count`, `first_err_idx`.
- `start` sampled at edge t gives `busy`=1 and `abc_out`=0 from t+1.
- Each vector occupies SETTLE+1 cycles: SETTLE drive cycles plus 1 sample cycle. `abc_out` is stable throughout those cycles.
- `y_in` is registered at the end of the SAMPLE cycle. The function under test therefore has SETTLE+1 cycles of combinational settle time.
- `done` occurs at t + 2^N_IN·(SETTLE+1) + 1. `busy` is 0 during DONE.
- All outputs are registered; none depend combinationally on `y_in` or `start`.

## Structure
- Shared package `tabla_pkg` holds:
  - the state enum (IDLE, DRIVE, SAMPLE, DONE);
  - constant `TABLA01_MUX_EXPECTED` (8-bit Tabla 01 reference column) for reuse by the 2:1/4:1/8:1 benches;
  - a function returning the vector count 2^N.
- One sub-module is natural: `settle_timer`, a loadable down-counter with a `expired` flag, parameterised by `SETTLE`. All other logic stays in `tabla_sweeper`.

## Test plan
- Reset, then `start` with `y_in` tied to `abc_out[0]`, TABLE=8'b1010_1010, SETTLE=1 → `abc_out` steps 0..7 every 2 cycles, `done` at cycle 17 after start, `pass`=1, `err_count`=0.
- Same TABLE with `y_in` tied to 0 → `err_count`=4, `first_err_idx`=1, `pass`=0.
- `y_in` driven by an 8:1 mux of Tabla 01, TABLE=`TABLA01_MUX_EXPECTED`, SETTLE=3 → `pass`=1, `done` at cycle 33 after start.
- `start` pulsed again at index 4 → ignored: the sweep completes unchanged and there is exactly one `done` pulse.
- `rst_n`=0 asserted during SAMPLE of index 5 → next cycle IDLE with all outputs 0. A fresh `start` then restarts at index 0 with `err_count`=0.
- `start` held high continuously → back-to-back sweeps, one `done` every 2^N_IN·(SETTLE+1)+1 cycles; `pass` stays valid between sweeps.
